// File: rtl/wb_sel_pipe.sv
// Registered write-back source selector: picks one of NCH channels, extends the
// narrow channel, and delivers the word through a 2-entry valid/ready skid buffer.
module wb_sel_pipe #(
  parameter int WIDTH       = 32,
  parameter int NCH         = 4,
  parameter int SELW        = 2,
  parameter int NARROW_CH   = 2,
  parameter int NARROW_W    = 10,
  parameter int NARROW_SEXT = 0
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic                  FLUSH,
  input  logic                  IN_VALID,
  output logic                  IN_READY,
  input  logic [SELW-1:0]       SEL,
  input  logic [NCH*WIDTH-1:0]  DIN,
  output logic                  OUT_VALID,
  input  logic                  OUT_READY,
  output logic [WIDTH-1:0]      OUT_DATA,
  output logic [SELW-1:0]       OUT_SEL,
  output logic                  OUT_ERR,
  output logic [1:0]            OCC
);

  localparam int               NSLOT      = 2**SELW;
  localparam logic [SELW:0]    NCH_L      = (SELW+1)'(NCH);
  localparam bit               HAS_NARROW = (NARROW_CH < NCH);
  localparam logic [SELW-1:0]  NARROW_SEL = SELW'(NARROW_CH);
  localparam logic [WIDTH-1:0] NMASK      = {WIDTH{1'b1}} >> (WIDTH - NARROW_W);

  // Encoding equals the buffered word count so OCC is a direct register decode.
  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_FULL  = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [WIDTH-1:0] chans [NSLOT];
  logic [WIDTH-1:0] ch;
  logic [WIDTH-1:0] in_data;
  logic             in_err;
  logic             accept;
  logic             ld_out_in, ld_sk_in, ld_out_sk;

  logic [WIDTH-1:0] out_data_q, sk_data_q;
  logic [SELW-1:0]  out_sel_q, sk_sel_q;
  logic             out_err_q, sk_err_q;

  // Unused select codes map to zero so the channel index never leaves the array.
  for (genvar k = 0; k < NSLOT; k++) begin : g_ch
    if (k < NCH) begin : g_used
      assign chans[k] = DIN[k*WIDTH +: WIDTH];
    end else begin : g_pad
      assign chans[k] = '0;
    end
  end

  always_comb begin
    in_err  = ({1'b0, SEL} >= NCH_L);
    ch      = chans[SEL];
    in_data = ch;
    if (HAS_NARROW && (SEL == NARROW_SEL)) begin
      if ((NARROW_SEXT != 0) && ch[NARROW_W-1]) in_data = ch | ~NMASK;
      else                                     in_data = ch & NMASK;
    end
    if (in_err) in_data = '0;
  end

  assign accept = IN_VALID && IN_READY && !FLUSH;

  always_ff @(posedge CLK) begin
    if (!RST_N) state_q <= S_EMPTY;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    ld_out_in = 1'b0;
    ld_sk_in  = 1'b0;
    ld_out_sk = 1'b0;
    case (state_q)
      S_EMPTY: begin
        if (accept) begin
          ld_out_in = 1'b1;
          state_d   = S_ONE;
        end
      end
      S_ONE: begin
        if (accept && OUT_READY) begin
          ld_out_in = 1'b1;
        end else if (accept) begin
          ld_sk_in = 1'b1;
          state_d  = S_FULL;
        end else if (OUT_READY) begin
          state_d = S_EMPTY;
        end
      end
      S_FULL: begin
        if (OUT_READY) begin
          ld_out_sk = 1'b1;
          state_d   = S_ONE;
        end
      end
      default: state_d = S_EMPTY;
    endcase
    if (FLUSH) begin
      state_d   = S_EMPTY;
      ld_sk_in  = 1'b0;
      ld_out_sk = 1'b0;
    end
  end

  always_comb begin
    OUT_VALID = (state_q != S_EMPTY);
    IN_READY  = (state_q != S_FULL);
    OCC       = state_q;
    OUT_DATA  = out_data_q;
    OUT_SEL   = out_sel_q;
    OUT_ERR   = out_err_q;
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      out_data_q <= '0;
      out_sel_q  <= '0;
      out_err_q  <= 1'b0;
      sk_data_q  <= '0;
      sk_sel_q   <= '0;
      sk_err_q   <= 1'b0;
    end else begin
      if (ld_out_in) begin
        out_data_q <= in_data;
        out_sel_q  <= SEL;
        out_err_q  <= in_err;
      end else if (ld_out_sk) begin
        out_data_q <= sk_data_q;
        out_sel_q  <= sk_sel_q;
        out_err_q  <= sk_err_q;
      end
      if (ld_sk_in) begin
        sk_data_q <= in_data;
        sk_sel_q  <= SEL;
        sk_err_q  <= in_err;
      end
    end
  end

endmodule

// File: tb/tb_wb_sel_pipe.sv
// Bench for wb_sel_pipe: two instances (default config, and NCH=3 with sign
// extension) driven in parallel and checked against a queue-based model.
module tb_wb_sel_pipe;

  typedef struct {
    logic [31:0] d;
    logic [1:0]  s;
    logic        e;
  } wb_t;

  logic         clk;
  logic         rst_n, flush, in_valid, out_ready;
  logic [1:0]   sel;
  logic [127:0] din;

  logic        a_in_ready, a_out_valid, a_out_err;
  logic [31:0] a_out_data;
  logic [1:0]  a_out_sel, a_occ;
  logic        b_in_ready, b_out_valid, b_out_err;
  logic [31:0] b_out_data;
  logic [1:0]  b_out_sel, b_occ;

  int checks   = 0;
  int failures = 0;
  wb_t qa[$];
  wb_t qb[$];

  wb_sel_pipe #(.WIDTH(32), .NCH(4), .SELW(2), .NARROW_CH(2), .NARROW_W(10), .NARROW_SEXT(0)) dut_a (
    .CLK(clk), .RST_N(rst_n), .FLUSH(flush), .IN_VALID(in_valid), .IN_READY(a_in_ready),
    .SEL(sel), .DIN(din), .OUT_VALID(a_out_valid), .OUT_READY(out_ready),
    .OUT_DATA(a_out_data), .OUT_SEL(a_out_sel), .OUT_ERR(a_out_err), .OCC(a_occ)
  );

  wb_sel_pipe #(.WIDTH(32), .NCH(3), .SELW(2), .NARROW_CH(2), .NARROW_W(10), .NARROW_SEXT(1)) dut_b (
    .CLK(clk), .RST_N(rst_n), .FLUSH(flush), .IN_VALID(in_valid), .IN_READY(b_in_ready),
    .SEL(sel), .DIN(din[95:0]), .OUT_VALID(b_out_valid), .OUT_READY(out_ready),
    .OUT_DATA(b_out_data), .OUT_SEL(b_out_sel), .OUT_ERR(b_out_err), .OCC(b_occ)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected stored word: channel value, low 10 bits of channel 2 extended arithmetically.
  function automatic wb_t model(input logic [1:0] s, input logic [127:0] d, input int nch, input bit sext);
    wb_t         w;
    logic [31:0] c;
    w.s = s;
    w.e = (int'(s) >= nch);
    w.d = 32'h0;
    if (!w.e) begin
      c = d[32*int'(s) +: 32];
      if (s == 2'd2) begin
        c = c % 32'd1024;
        if (sext && c >= 32'd512) c = c - 32'd1024;
      end
      w.d = c;
    end
    return w;
  endfunction

  task automatic set_ch(input int k, input logic [31:0] v);
    din[k*32 +: 32] = v;
  endtask

  // Advance the model with the inputs about to be sampled, then step one edge.
  task automatic cycle();
    bit acc_a, acc_b;
    if (!rst_n) begin
      qa.delete();
      qb.delete();
    end else begin
      acc_a = in_valid && (qa.size() < 2) && !flush;
      acc_b = in_valid && (qb.size() < 2) && !flush;
      if (qa.size() > 0 && out_ready) void'(qa.pop_front());
      if (qb.size() > 0 && out_ready) void'(qb.pop_front());
      if (flush) begin
        qa.delete();
        qb.delete();
      end else begin
        if (acc_a) qa.push_back(model(sel, din, 4, 1'b0));
        if (acc_b) qb.push_back(model(sel, {32'h0, din[95:0]}, 3, 1'b1));
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; sel = 2'd0; din = '0;
    cycle();
    cycle();
    checks++;
    if ({a_out_valid, a_out_data, a_out_sel, a_out_err, a_occ, a_in_ready} !== {1'b0, 32'h0, 2'd0, 1'b0, 2'd0, 1'b1}) begin
      failures++;
      $display("FAIL reset_a got v=%b d=%h s=%0d e=%b occ=%0d rdy=%b exp v=0 d=0 s=0 e=0 occ=0 rdy=1",
               a_out_valid, a_out_data, a_out_sel, a_out_err, a_occ, a_in_ready);
    end
    checks++;
    if ({b_out_valid, b_out_data, b_out_sel, b_out_err, b_occ, b_in_ready} !== {1'b0, 32'h0, 2'd0, 1'b0, 2'd0, 1'b1}) begin
      failures++;
      $display("FAIL reset_b got v=%b d=%h s=%0d e=%b occ=%0d rdy=%b exp v=0 d=0 s=0 e=0 occ=0 rdy=1",
               b_out_valid, b_out_data, b_out_sel, b_out_err, b_occ, b_in_ready);
    end
    rst_n = 1'b1;
    cycle();
  endtask

  task automatic test_basic();
    logic [31:0] exp_d [4];
    exp_d[0] = 32'h11111111; exp_d[1] = 32'h22222222; exp_d[2] = 32'h000003FF; exp_d[3] = 32'h44444444;
    for (int k = 0; k < 4; k++) set_ch(k, exp_d[k]);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    for (int s = 0; s < 4; s++) begin
      sel = 2'(s);
      cycle();
      checks++;
      if ({a_out_valid, a_out_data, a_out_sel, a_out_err} !== {1'b1, exp_d[s], 2'(s), 1'b0} || a_occ > 2'd1) begin
        failures++;
        $display("FAIL basic_sel%0d got v=%b d=%h s=%0d e=%b occ=%0d exp v=1 d=%h s=%0d e=0 occ<=1",
                 s, a_out_valid, a_out_data, a_out_sel, a_out_err, a_occ, exp_d[s], s);
      end
    end
    in_valid = 1'b0;
    cycle();
    checks++;
    if ({a_out_valid, a_occ} !== {1'b0, 2'd0}) begin
      failures++;
      $display("FAIL basic_drain got v=%b occ=%0d exp v=0 occ=0", a_out_valid, a_occ);
    end
  endtask

  task automatic test_sext();
    out_ready = 1'b1;
    in_valid  = 1'b1;
    sel       = 2'd2;
    set_ch(2, 32'hFFFFF200);
    cycle();
    checks++;
    if (b_out_data !== 32'hFFFFFE00) begin
      failures++;
      $display("FAIL sext_neg got %h exp FFFFFE00", b_out_data);
    end
    checks++;
    if (a_out_data !== 32'h00000200) begin
      failures++;
      $display("FAIL zext_upper got %h exp 00000200", a_out_data);
    end
    set_ch(2, 32'h00000155);
    cycle();
    checks++;
    if (b_out_data !== 32'h00000155) begin
      failures++;
      $display("FAIL sext_pos got %h exp 00000155", b_out_data);
    end
    in_valid = 1'b0;
    cycle();
  endtask

  task automatic test_backpressure();
    logic [31:0] w [3];
    logic [31:0] exp_d [3];
    logic [1:0]  exp_o [3];
    w[0] = 32'hAAAA0001; w[1] = 32'hBBBB0002; w[2] = 32'hCCCC0003;
    out_ready = 1'b0;
    in_valid  = 1'b1;
    sel       = 2'd0;
    for (int i = 0; i < 3; i++) begin
      set_ch(0, w[i]);
      cycle();
    end
    checks++;
    if ({a_out_valid, a_occ, a_in_ready, a_out_data} !== {1'b1, 2'd2, 1'b0, w[0]}) begin
      failures++;
      $display("FAIL bp_full got v=%b occ=%0d rdy=%b d=%h exp v=1 occ=2 rdy=0 d=%h",
               a_out_valid, a_occ, a_in_ready, a_out_data, w[0]);
    end
    exp_d[0] = w[1]; exp_d[1] = w[2]; exp_d[2] = 32'h0;
    exp_o[0] = 2'd1; exp_o[1] = 2'd1; exp_o[2] = 2'd0;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      if (i == 2) in_valid = 1'b0;
      cycle();
      checks++;
      if (a_occ !== exp_o[i] || (exp_o[i] != 2'd0 && (a_out_data !== exp_d[i] || a_in_ready !== 1'b1))) begin
        failures++;
        $display("FAIL bp_drain%0d got occ=%0d d=%h rdy=%b exp occ=%0d d=%h rdy=1",
                 i, a_occ, a_out_data, a_in_ready, exp_o[i], exp_d[i]);
      end
    end
  endtask

  task automatic test_illegal();
    out_ready = 1'b1;
    in_valid  = 1'b1;
    sel       = 2'd3;
    set_ch(3, 32'h5A5A5A5A);
    cycle();
    checks++;
    if ({b_out_valid, b_out_data, b_out_sel, b_out_err} !== {1'b1, 32'h0, 2'd3, 1'b1}) begin
      failures++;
      $display("FAIL illegal_sel got v=%b d=%h s=%0d e=%b exp v=1 d=0 s=3 e=1",
               b_out_valid, b_out_data, b_out_sel, b_out_err);
    end
    checks++;
    if ({a_out_data, a_out_err} !== {32'h5A5A5A5A, 1'b0}) begin
      failures++;
      $display("FAIL legal_ch3 got d=%h e=%b exp d=5A5A5A5A e=0", a_out_data, a_out_err);
    end
    sel = 2'd1;
    set_ch(1, 32'h0BADCAFE);
    cycle();
    checks++;
    if ({b_out_data, b_out_sel, b_out_err} !== {32'h0BADCAFE, 2'd1, 1'b0}) begin
      failures++;
      $display("FAIL after_illegal got d=%h s=%0d e=%b exp d=0BADCAFE s=1 e=0", b_out_data, b_out_sel, b_out_err);
    end
    in_valid = 1'b0;
    cycle();
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    sel       = 2'd0;
    set_ch(0, 32'h12340000);
    cycle();
    cycle();
    set_ch(0, 32'hDEADBEEF);
    flush = 1'b1;
    cycle();
    checks++;
    if ({a_occ, a_out_valid, a_in_ready} !== {2'd0, 1'b0, 1'b1}) begin
      failures++;
      $display("FAIL flush_full got occ=%0d v=%b rdy=%b exp occ=0 v=0 rdy=1", a_occ, a_out_valid, a_in_ready);
    end
    flush = 1'b0;
    cycle();
    flush     = 1'b1;
    out_ready = 1'b1;
    set_ch(0, 32'hFEEDF00D);
    cycle();
    flush    = 1'b0;
    in_valid = 1'b0;
    cycle();
    checks++;
    if ({a_occ, a_out_valid} !== {2'd0, 1'b0}) begin
      failures++;
      $display("FAIL flush_one_drop got occ=%0d v=%b d=%h exp occ=0 v=0", a_occ, a_out_valid, a_out_data);
    end
  endtask

  task automatic test_reset_stall();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    sel       = 2'd1;
    set_ch(1, 32'h77778888);
    cycle();
    cycle();
    rst_n = 1'b0;
    cycle();
    checks++;
    if ({a_out_valid, a_out_data, a_out_sel, a_out_err, a_occ, a_in_ready} !== {1'b0, 32'h0, 2'd0, 1'b0, 2'd0, 1'b1}) begin
      failures++;
      $display("FAIL reset_stall got v=%b d=%h s=%0d e=%b occ=%0d rdy=%b exp v=0 d=0 s=0 e=0 occ=0 rdy=1",
               a_out_valid, a_out_data, a_out_sel, a_out_err, a_occ, a_in_ready);
    end
    rst_n     = 1'b1;
    out_ready = 1'b1;
    sel       = 2'd0;
    set_ch(0, 32'hE0E0E0E0);
    cycle();
    checks++;
    if ({a_out_valid, a_out_data, a_occ} !== {1'b1, 32'hE0E0E0E0, 2'd1}) begin
      failures++;
      $display("FAIL after_reset got v=%b d=%h occ=%0d exp v=1 d=E0E0E0E0 occ=1", a_out_valid, a_out_data, a_occ);
    end
    in_valid = 1'b0;
    cycle();
  endtask

  task automatic test_random();
    for (int n = 0; n < 600; n++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 15) == 0);
      rst_n     = ($urandom_range(0, 63) != 0);
      sel       = 2'($urandom_range(0, 3));
      for (int k = 0; k < 4; k++) set_ch(k, $urandom());
      cycle();
      checks++;
      if ({a_out_valid, a_occ, a_in_ready} !== {qa.size() > 0, 2'(qa.size()), qa.size() < 2}) begin
        failures++;
        $display("FAIL rand_a_status n=%0d got v=%b occ=%0d rdy=%b exp occ=%0d", n, a_out_valid, a_occ, a_in_ready, qa.size());
      end
      if (qa.size() > 0) begin
        checks++;
        if ({a_out_data, a_out_sel, a_out_err} !== {qa[0].d, qa[0].s, qa[0].e}) begin
          failures++;
          $display("FAIL rand_a_word n=%0d got d=%h s=%0d e=%b exp d=%h s=%0d e=%b",
                   n, a_out_data, a_out_sel, a_out_err, qa[0].d, qa[0].s, qa[0].e);
        end
      end
      checks++;
      if ({b_out_valid, b_occ, b_in_ready} !== {qb.size() > 0, 2'(qb.size()), qb.size() < 2}) begin
        failures++;
        $display("FAIL rand_b_status n=%0d got v=%b occ=%0d rdy=%b exp occ=%0d", n, b_out_valid, b_occ, b_in_ready, qb.size());
      end
      if (qb.size() > 0) begin
        checks++;
        if ({b_out_data, b_out_sel, b_out_err} !== {qb[0].d, qb[0].s, qb[0].e}) begin
          failures++;
          $display("FAIL rand_b_word n=%0d got d=%h s=%0d e=%b exp d=%h s=%0d e=%b",
                   n, b_out_data, b_out_sel, b_out_err, qb[0].d, qb[0].s, qb[0].e);
        end
      end
    end
    rst_n    = 1'b1;
    flush    = 1'b0;
    in_valid = 1'b0;
    cycle();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_sext();
    test_backpressure();
    test_illegal();
    test_flush();
    test_reset_stall();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
